mont_inv_sched: RTL and testbench

Round-robin scheduler that shares one multi-word Montgomery inversion unit (`Mont_inv_multi`) between `NREQ` requesters. A granted requester streams its operand words (address + data) through the block, which drives the unit's start, write-address and write-data inputs. The block then waits for the unit's busy cycle to finish and signals completion back to that requester. It sits between the pairing-datapath controllers and the single inverter instance.

---
 rtl/mont_inv_sched.sv | 169 ++++++++++++++++
 tb/tb_mont_inv_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_inv_sched.sv
// mont_inv_sched: round-robin front end that lets NREQ pairing controllers
// take turns loading and launching the single shared Montgomery inverter.
//
// Word handshake: a word transfers on a rising edge where the granted
// requester holds I_WVALID[g]=1 and O_WREADY[g]=1. Valid may rise before
// ready and must hold its address/data/last until that edge. Ready is only
// ever driven on the granted bit and only while loading.
module mont_inv_sched #(
  parameter int NREQ      = 4,
  parameter int W         = 384,
  parameter int AW        = 9,
  parameter int MAXW      = 8,
  parameter int LAUNCH_TO = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   I_REQ,
  input  logic [NREQ-1:0]   I_WVALID,
  input  logic [NREQ-1:0]   I_WLAST,
  input  logic [NREQ*AW-1:0] I_WADDR,
  input  logic [NREQ*W-1:0] I_WDATA,
  output logic [NREQ-1:0]   O_WREADY,
  output logic [NREQ-1:0]   O_GNT,
  output logic [NREQ-1:0]   O_DONE,
  output logic              O_ERR,
  output logic              O_BUSY,
  output logic              O_INV_START,
  output logic [AW-1:0]     O_INV_WADDR,
  output logic [W-1:0]      O_INV_WDATA,
  input  logic              I_INV_BUSY,
  output logic [2:0]        O_STATE
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXW + 1);
  localparam int TW = $clog2(LAUNCH_TO + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]      state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic [CW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;
  logic            start_q;
  logic [AW-1:0]   waddr_q;
  logic [W-1:0]    wdata_q;

  logic            arb_found;
  logic [GW-1:0]   arb_idx;
  logic [GW:0]     arb_j;

  logic            sel_valid;
  logic            sel_last;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_data;
  logic            accept;
  logic            last_word;
  logic            timeout;

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_j = {1'b0, rr_ptr} + (GW+1)'(i);
      if (arb_j >= (GW+1)'(NREQ)) arb_j = arb_j - (GW+1)'(NREQ);
      if (!arb_found && I_REQ[arb_j[GW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_j[GW-1:0];
      end
    end
  end

  // Granted requester's word channel, plus transfer/termination decode.
  always_comb begin
    sel_valid = I_WVALID[gidx];
    sel_last  = I_WLAST[gidx];
    sel_addr  = I_WADDR[gidx*AW +: AW];
    sel_data  = I_WDATA[gidx*W +: W];
    accept    = (state == S_LOAD) && sel_valid;
    // The MAXW-th word ends the job even without a last marker.
    last_word = sel_last || (wcnt == CW'(MAXW - 1));
    // Counter only advances once start is low, so the match lands exactly
    // LAUNCH_TO cycles after the start fall.
    timeout   = (state == S_LAUNCH) && !I_INV_BUSY && (tcnt == TW'(LAUNCH_TO));
  end

  // Job sequencing, grant/pointer bookkeeping and the registered inverter bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      gidx    <= '0;
      gnt     <= '0;
      wcnt    <= '0;
      tcnt    <= '0;
      start_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|I_REQ) state <= S_ARB;
        end
        S_ARB: begin
          wcnt <= '0;
          if (arb_found) begin
            gidx  <= arb_idx;
            gnt   <= NREQ'(1) << arb_idx;
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          // Gap cycles leave start high and the bus untouched, so the
          // inverter harmlessly rewrites the same word.
          if (accept) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
            start_q <= 1'b1;
            wcnt    <= wcnt + CW'(1);
            if (last_word) begin
              tcnt  <= '0;
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b0;
          if (!start_q) tcnt <= tcnt + TW'(1);
          if (I_INV_BUSY) state <= S_RUN;
          else if (tcnt == TW'(LAUNCH_TO)) state <= S_DONE;
        end
        S_RUN: begin
          if (!I_INV_BUSY) state <= S_DONE;
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= (gidx == GW'(NREQ - 1)) ? '0 : gidx + GW'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from registered state only (plus busy for the error pulse).
  always_comb begin
    O_GNT       = gnt;
    O_WREADY    = (state == S_LOAD) ? gnt : '0;
    O_DONE      = (state == S_DONE) ? gnt : '0;
    O_ERR       = timeout;
    O_BUSY      = (state != S_IDLE);
    O_INV_START = start_q;
    O_INV_WADDR = waddr_q;
    O_INV_WDATA = wdata_q;
    O_STATE     = state;
  end

endmodule

// File: tb/tb_mont_inv_sched.sv
// Directed bench for mont_inv_sched: drives requesters, models the
// inverter's busy response and checks bus contents, pulse timing and grants.
module tb_mont_inv_sched;

  localparam int NREQ = 4;
  localparam int W    = 384;
  localparam int AW   = 9;
  localparam int LTO  = 16;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   wvalid;
  logic [NREQ-1:0]   wlast;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   O_WREADY, O_GNT, O_DONE;
  logic              O_ERR, O_BUSY, O_INV_START;
  logic [AW-1:0]     O_INV_WADDR;
  logic [W-1:0]      O_INV_WDATA;
  logic              inv_busy;
  logic [2:0]        O_STATE;

  mont_inv_sched #(.NREQ(NREQ), .W(W), .AW(AW), .MAXW(8), .LAUNCH_TO(LTO)) dut (
    .clk(clk), .rstn(rstn),
    .I_REQ(req), .I_WVALID(wvalid), .I_WLAST(wlast),
    .I_WADDR(waddr), .I_WDATA(wdata),
    .O_WREADY(O_WREADY), .O_GNT(O_GNT), .O_DONE(O_DONE),
    .O_ERR(O_ERR), .O_BUSY(O_BUSY), .O_INV_START(O_INV_START),
    .O_INV_WADDR(O_INV_WADDR), .O_INV_WDATA(O_INV_WDATA),
    .I_INV_BUSY(inv_busy), .O_STATE(O_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc++;

  // ---------------- counters / scoreboard ----------------
  int errors;
  int checks;
  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] obs_q[$];
  logic [NREQ-1:0] gnt_q[$];

  int start_hi, rise_cyc, fall_cyc, done_cnt, done_cyc, err_cnt, err_cyc;
  int bfall_cyc, gnt_cyc, req_cyc, wr_bad;
  logic [NREQ-1:0] done_vec, gnt_d;
  logic start_d, busy_d;

  logic [AW-1:0] drv_a [NREQ][12];
  int acc [NREQ];

  // inverter model controls
  bit mdl_en;
  int busy_len;
  logic mdl_prev;

  function automatic logic [W-1:0] mkdata(input logic [AW-1:0] a);
    return {12{23'h2a5a5a, a}};
  endfunction

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    exp_q.delete();
    obs_q.delete();
    gnt_q.delete();
    start_hi = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (O_INV_START) begin
      start_hi++;
      obs_q.push_back({O_INV_WADDR, O_INV_WDATA});
      if (!start_d) rise_cyc = cyc;
    end
    if (start_d && !O_INV_START) fall_cyc = cyc;
    start_d = O_INV_START;
    if (|O_DONE) begin done_cnt++; done_cyc = cyc; done_vec = O_DONE; end
    if (O_ERR) begin err_cnt++; err_cyc = cyc; end
    if (O_GNT != gnt_d && O_GNT != '0) begin gnt_q.push_back(O_GNT); gnt_cyc = cyc; end
    gnt_d = O_GNT;
    if (busy_d && !inv_busy) bfall_cyc = cyc;
    busy_d = inv_busy;
    if ((O_WREADY & ~O_GNT) != '0) wr_bad++;
  end

  // ---------------- inverter busy model ----------------
  initial begin
    inv_busy = 1'b0;
    mdl_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mdl_prev && !O_INV_START && mdl_en) begin
        repeat (2) @(posedge clk);
        #1 inv_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 inv_busy = 1'b0;
      end
      mdl_prev = O_INV_START;
    end
  end

  // ---------------- driver ----------------
  // Streams nw words from drv_a[n]; request drops after the first accepted
  // word (the grant must hold regardless). Optional idle gap after word gap_at.
  task automatic drive_job(input int n, input int nw, input bit mark_last,
                           input int gap_at, input int gap_len, output int accepted);
    int k;
    int waitc;
    accepted = 0;
    k = 0;
    @(posedge clk);
    #1 req[n] = 1'b1;
    req_cyc = cyc;
    while (k < nw) begin
      waddr[n*AW +: AW] = drv_a[n][k];
      wdata[n*W +: W]   = mkdata(drv_a[n][k]);
      wlast[n]  = mark_last && (k == nw - 1);
      wvalid[n] = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!O_WREADY[n] && waitc < 100) begin
        waitc++;
        @(negedge clk);
      end
      if (!O_WREADY[n]) break;
      @(posedge clk);
      #1;
      accepted++;
      k++;
      req[n]    = 1'b0;
      wvalid[n] = 1'b0;
      wlast[n]  = 1'b0;
      if (k == gap_at) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    wvalid[n] = 1'b0;
    wlast[n]  = 1'b0;
    req[n]    = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int c;
    c = 0;
    while (done_cnt < target && c < 600) begin
      c++;
      @(negedge clk);
    end
    chk(tag, 400'(done_cnt >= target), 400'(1));
  endtask

  task automatic check_bus(input string tag);
    chk({tag, "_len"}, 400'(obs_q.size()), 400'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 400'(obs_q[i]), 400'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a;
    int dbase;
    errors = 0; checks = 0; wr_bad = 0;
    rstn = 1'b0; req = '0; wvalid = '0; wlast = '0; waddr = '0; wdata = '0;
    mdl_en = 1'b1; busy_len = 5;
    gnt_d = '0; start_d = 1'b0; busy_d = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 400'({O_GNT, O_WREADY, O_DONE, O_ERR, O_BUSY, O_INV_START}), 400'(0));
    chk("rst_addr", 400'(O_INV_WADDR), 400'(0));
    chk("rst_data", 400'(O_INV_WDATA), 400'(0));
    chk("rst_state", 400'(O_STATE), 400'(0));
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Round robin: everyone at once, then 0 and 2 again.
    clear_mon();
    for (int n = 0; n < NREQ; n++) drv_a[n][0] = 9'h30 + 9'(n);
    fork
      drive_job(0, 1, 1'b1, -1, 0, acc[0]);
      drive_job(1, 1, 1'b1, -1, 0, acc[1]);
      drive_job(2, 1, 1'b1, -1, 0, acc[2]);
      drive_job(3, 1, 1'b1, -1, 0, acc[3]);
    join
    wait_done(4, "rr1_done");
    repeat (3) @(posedge clk);
    fork
      drive_job(0, 1, 1'b1, -1, 0, acc[0]);
      drive_job(2, 1, 1'b1, -1, 0, acc[2]);
    join
    wait_done(6, "rr2_done");
    chk("rr_ngnt", 400'(gnt_q.size()), 400'(6));
    if (gnt_q.size() == 6) begin
      chk("rr_order", 400'({gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3], gnt_q[4], gnt_q[5]}),
          400'(24'h124814));
    end
    chk("rr_acc3", 400'(acc[3]), 400'(1));
    repeat (3) @(posedge clk);

    // Single 6-word job, busy held 50 cycles.
    clear_mon();
    busy_len = 50;
    drv_a[0][0] = 9'h11; drv_a[0][1] = 9'h12; drv_a[0][2] = 9'h13;
    drv_a[0][3] = 9'h15; drv_a[0][4] = 9'h16; drv_a[0][5] = 9'h17;
    for (int i = 0; i < 6; i++) exp_q.push_back({drv_a[0][i], mkdata(drv_a[0][i])});
    drive_job(0, 6, 1'b1, -1, 0, a);
    chk("sj_gnt_lat", 400'(gnt_cyc - req_cyc), 400'(2));
    wait_done(1, "sj_done");
    chk("sj_acc", 400'(a), 400'(6));
    chk("sj_start_hi", 400'(start_hi), 400'(6));
    chk("sj_start_run", 400'(fall_cyc - rise_cyc), 400'(6));
    check_bus("sj_bus");
    chk("sj_done_vec", 400'(done_vec), 400'(4'b0001));
    chk("sj_done_lat", 400'(done_cyc - bfall_cyc), 400'(1));
    repeat (3) @(posedge clk);
    chk("sj_done_once", 400'(done_cnt), 400'(1));

    // Gap hold: 0x22, three idle cycles, 0x23 last.
    clear_mon();
    busy_len = 5;
    drv_a[1][0] = 9'h22; drv_a[1][1] = 9'h23;
    for (int i = 0; i < 4; i++) exp_q.push_back({9'h022, mkdata(9'h022)});
    exp_q.push_back({9'h023, mkdata(9'h023)});
    drive_job(1, 2, 1'b1, 1, 3, a);
    wait_done(1, "gap_done");
    chk("gap_start_hi", 400'(start_hi), 400'(5));
    chk("gap_start_run", 400'(fall_cyc - rise_cyc), 400'(5));
    check_bus("gap_bus");
    chk("gap_done_vec", 400'(done_vec), 400'(4'b0010));
    repeat (3) @(posedge clk);

    // Forced last: 10 words offered without a last marker.
    clear_mon();
    for (int i = 0; i < 10; i++) drv_a[2][i] = 9'h40 + 9'(i);
    for (int i = 0; i < 8; i++) exp_q.push_back({drv_a[2][i], mkdata(drv_a[2][i])});
    drive_job(2, 10, 1'b0, -1, 0, a);
    wait_done(1, "fl_done");
    chk("fl_acc", 400'(a), 400'(8));
    chk("fl_start_hi", 400'(start_hi), 400'(8));
    check_bus("fl_bus");
    chk("fl_done_vec", 400'(done_vec), 400'(4'b0100));
    chk("fl_done_once", 400'(done_cnt), 400'(1));
    repeat (3) @(posedge clk);

    // Launch timeout: inverter never goes busy.
    clear_mon();
    mdl_en = 1'b0;
    drv_a[1][0] = 9'h50;
    drive_job(1, 1, 1'b1, -1, 0, a);
    wait_done(1, "to_done");
    chk("to_err_cnt", 400'(err_cnt), 400'(1));
    chk("to_err_lat", 400'(err_cyc - fall_cyc), 400'(LTO));
    chk("to_done_lat", 400'(done_cyc - err_cyc), 400'(1));
    chk("to_done_vec", 400'(done_vec), 400'(4'b0010));
    @(negedge clk);
    chk("to_idle", 400'({O_BUSY, O_STATE}), 400'(0));
    mdl_en = 1'b1;
    repeat (3) @(posedge clk);

    // Asynchronous reset while the inverter is busy, then rr_ptr=0 ordering.
    clear_mon();
    busy_len = 40;
    drv_a[2][0] = 9'h60;
    drive_job(2, 1, 1'b1, -1, 0, a);
    for (int c = 0; c < 50 && !inv_busy; c++) @(negedge clk);
    chk("ar_busy_seen", 400'(inv_busy), 400'(1));
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("ar_ctl", 400'({O_GNT, O_WREADY, O_DONE, O_ERR, O_BUSY, O_INV_START}), 400'(0));
    chk("ar_addr", 400'(O_INV_WADDR), 400'(0));
    chk("ar_data", 400'(O_INV_WDATA), 400'(0));
    dbase = done_cnt;
    for (int c = 0; c < 60 && inv_busy; c++) @(negedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    chk("ar_no_done", 400'(done_cnt), 400'(dbase));
    clear_mon();
    busy_len = 5;
    drv_a[3][0] = 9'h73; drv_a[1][0] = 9'h71;
    fork
      drive_job(3, 1, 1'b1, -1, 0, acc[3]);
      drive_job(1, 1, 1'b1, -1, 0, acc[1]);
    join
    wait_done(2, "ar_jobs_done");
    chk("ar_ngnt", 400'(gnt_q.size()), 400'(2));
    if (gnt_q.size() == 2) chk("ar_order", 400'({gnt_q[0], gnt_q[1]}), 400'(8'h28));
    chk("ar_acc3", 400'(acc[3]), 400'(1));
    chk("wready_only_gnt", 400'(wr_bad), 400'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
